aes_output_collector: RTL
=========================

# aes_output_collector

Downstream companion of the byte-serial AES encryption core. Captures the 16 ciphertext bytes streamed on the core's `data_out`/`ready` pair and reassembles them into 128-bit blocks, MSB byte first. Buffers completed blocks in a small FIFO and presents them to a word-wide consumer through a valid/ack handshake. Flags truncated bursts and buffer overflow.

## Interface

**Parameters**
- `DEPTH`, 2: FIFO entries. Power of two, ≥2.
- `LEAD_SKIP`, 1: number of stale cycles ignored after `ready_in` is first seen high. The encryption core raises `ready` one cycle before its first valid byte.

**Ports**
- `clk`, in, 1: single clock; all logic on rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `ready_in`, in, 1: the encryption core's `ready`.
- `data_in`, in, 8: the encryption core's `data_out`.
- `block_out`, out, 128: FIFO head block. Byte 0 is at [127:120].
- `block_valid`, out, 1: FIFO non-empty.
- `block_ack`, in, 1: consumer pops the head when `block_valid` is high.
- `err_short`, out, 1: sticky. A burst ended before 16 bytes were captured.
- `err_overflow`, out, 1: sticky. A completed block was dropped because the FIFO was full.
- `clr_err`, in, 1: synchronous clear of both sticky flags.
- `block_count`, out, 16: number of blocks written into the FIFO. Wraps from 0xFFFF to 0.

## Operation

- Assembly uses a 128-bit shift register. Each capture shifts left 8 bits and inserts `data_in` at [7:0], so after 16 captures the first byte sits at [127:120].
- A 4-bit byte counter tracks captures. An 8-bit skip counter tracks leading stale cycles.
- **FSM states:** IDLE, SKIP, COLLECT, DRAIN.
  - **IDLE:** if `ready_in`=1, go to SKIP, load the skip counter, and clear the byte counter. If `LEAD_SKIP`=0, go straight to COLLECT and capture in that same cycle.
  - **SKIP:** ignore `data_in`. Decrement the skip counter each cycle; when it reaches 0, go to COLLECT. If `ready_in`=0 here, set `err_short` and go to IDLE.
  - **COLLECT:** while `ready_in`=1, capture `data_in` and increment the byte counter.
    - On the 16th capture: push the assembled word (including that byte) into the FIFO and go to DRAIN.
    - If `ready_in`=0 before 16 captures: set `err_short`, discard the partial word, and go to IDLE. No FIFO write.
  - **DRAIN:** wait for `ready_in`=0, then go to IDLE. Bytes arriving in DRAIN are ignored. A second burst requires `ready_in` to deassert first.
- **FIFO:**
  - Write pointer, read pointer, and occupancy count. Pointers wrap modulo `DEPTH`.
  - Read occurs when `block_valid`&`block_ack`.
  - A push is accepted if occupancy < `DEPTH`, or if a read happens in the same cycle. Simultaneous read and write at full is legal and occupancy is unchanged.
  - A push to a full FIFO with no read is dropped: set `err_overflow`; `block_count` does not increment.
  - Simultaneous read and write when empty: the write is accepted and the read is ignored, because `block_valid` was 0.
  - `block_ack` while `block_valid`=0 has no effect.
- `block_count` increments on every accepted push.
- **Sticky flags:** an error event and `clr_err` in the same cycle leave the flag set (set wins).

## Timing

- **Reset (asynchronous):** FSM=IDLE; counters, pointers and occupancy=0; shift register=0; `block_out`=0; `block_valid`=0; `err_short`=0; `err_overflow`=0; `block_count`=0.
- **Reset mid-burst:** the partial block is lost. After `reset` releases, the FSM starts in IDLE and the next burst requires `ready_in` to be seen high from IDLE. A burst already in progress at release is captured from its current position and flagged as `err_short` if it ends early.
- **Burst timing:** `ready_in` is first sampled high at edge E0. With `LEAD_SKIP`=1, bytes are captured at edges E1..E16.
- **Latency:** `block_valid` rises after edge E16, with the complete word on `block_out`. Latency is one cycle from the last byte to valid.
- **Throughput:** the core's 17-cycle `ready` burst (1 stale cycle + 16 bytes) yields exactly one block.
- **Handshake:** `block_out` is held stable while `block_valid`=1 and `block_ack`=0. After a pop, the next entry appears the following cycle.
- **Outputs:** all registered. FIFO storage and head read are synchronous to the registered pointers, with no combinational path from `block_ack` to `block_out`.

## Test plan

- **FIPS-197 vector:** feed the core's burst for ciphertext 3925841d02dc09fbdc118597196a0b32, preceded by one stale byte 0x00, with `block_ack`=0.
  - Expect `block_out`=3925841d02dc09fbdc118597196a0b32 and `block_valid`=1 one cycle after the 16th byte.
  - Expect `block_count`=1.
- **Short burst:** `ready_in` high for 1+10 cycles, then low.
  - Expect `err_short`=1, `block_valid`=0, `block_count`=0.
  - `clr_err` pulse → `err_short`=0.
- **Overflow:** three back-to-back full bursts (blocks A, B, C) with `block_ack`=0 and `DEPTH`=2.
  - Expect `err_overflow`=1 after C and `block_count`=2.
  - Then pop twice and expect A then B.
- **Full with simultaneous pop:** FIFO full; `block_ack`=1 in the same cycle a third block completes.
  - Expect no overflow, occupancy stays 2, `block_count`=3.
  - Subsequent pops yield B then C.
- **Async reset mid-COLLECT:** assert `reset` between clock edges after 8 bytes.
  - Expect all outputs to go to 0 immediately.
  - A fresh full burst after release yields a correct block, with `block_count`=1.
- **`LEAD_SKIP`=0 build:** bytes valid from the first `ready_in` cycle.
  - Expect the same output block as the FIPS-197 vector, one cycle earlier relative to E0.

Source files
------------

// File: rtl/aes_output_collector.sv
// Reassembles the byte-serial ciphertext stream of the AES core into 128-bit
// blocks (first byte at the MSB end) and buffers them in a small FIFO.
module aes_output_collector #(
  parameter int DEPTH     = 2,
  parameter int LEAD_SKIP = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ready_in,
  input  logic [7:0]   data_in,
  output logic [127:0] block_out,
  output logic         block_valid,
  input  logic         block_ack,
  output logic         err_short,
  output logic         err_overflow,
  input  logic         clr_err,
  output logic [15:0]  block_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, SKIP, COLLECT, DRAIN} state_t;

  state_t         r_state;
  state_t         w_next;
  logic [7:0]     r_skip;
  logic [3:0]     r_bytes;
  logic [127:0]   r_shift;
  logic [127:0]   w_word;

  logic           w_capture;
  logic           w_push;
  logic           w_short;
  logic           w_load_skip;
  logic           w_dec_skip;
  logic           w_clear_bytes;

  logic [127:0]   r_mem [DEPTH];
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic [CW-1:0]  w_count_next;
  logic           r_valid;
  logic           w_rd;
  logic           w_accept;
  logic           w_drop;
  logic           r_err_short;
  logic           r_err_overflow;
  logic [15:0]    r_block_count;

  assign w_word = {r_shift[119:0], data_in};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // The IDLE cycle that first sees ready_in already counts as one stale cycle,
  // so SKIP is only visited when more than one stale cycle must be dropped.
  always_comb begin
    w_next        = r_state;
    w_capture     = 1'b0;
    w_push        = 1'b0;
    w_short       = 1'b0;
    w_load_skip   = 1'b0;
    w_dec_skip    = 1'b0;
    w_clear_bytes = 1'b0;
    case (r_state)
      IDLE: begin
        if (ready_in) begin
          w_clear_bytes = 1'b1;
          if (LEAD_SKIP == 0) begin
            w_capture = 1'b1;
            w_next    = COLLECT;
          end else if (LEAD_SKIP == 1) begin
            w_next = COLLECT;
          end else begin
            w_load_skip = 1'b1;
            w_next      = SKIP;
          end
        end
      end
      SKIP: begin
        if (!ready_in) begin
          w_short = 1'b1;
          w_next  = IDLE;
        end else begin
          w_dec_skip = 1'b1;
          if (r_skip == 8'd1) w_next = COLLECT;
        end
      end
      COLLECT: begin
        if (!ready_in) begin
          w_short = 1'b1;
          w_next  = IDLE;
        end else begin
          w_capture = 1'b1;
          if (r_bytes == 4'd15) begin
            w_push = 1'b1;
            w_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!ready_in) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_skip  <= 8'd0;
      r_bytes <= 4'd0;
      r_shift <= 128'd0;
    end else begin
      if (w_load_skip)     r_skip <= 8'(LEAD_SKIP - 1);
      else if (w_dec_skip) r_skip <= r_skip - 8'd1;
      if (w_clear_bytes)   r_bytes <= {3'b000, w_capture};
      else if (w_capture)  r_bytes <= r_bytes + 4'd1;
      if (w_capture)       r_shift <= w_word;
    end
  end

  // A pop is only real when the head was valid; a pop frees the slot the
  // incoming block needs, so push at full is accepted in that case.
  assign w_rd     = r_valid & block_ack;
  assign w_accept = w_push & ((r_count < CW'(DEPTH)) | w_rd);
  assign w_drop   = w_push & ~w_accept;

  always_comb begin
    w_count_next = r_count;
    case ({w_accept, w_rd})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 128'd0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_valid       <= 1'b0;
      r_block_count <= 16'd0;
    end else begin
      if (w_accept) begin
        r_mem[r_wr_ptr] <= w_word;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
        r_block_count   <= r_block_count + 16'd1;
      end
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_next;
      r_valid <= (w_count_next != '0);
    end
  end

  // Error events take priority over a clear arriving in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_short    <= 1'b0;
      r_err_overflow <= 1'b0;
    end else begin
      if (w_short)      r_err_short <= 1'b1;
      else if (clr_err) r_err_short <= 1'b0;
      if (w_drop)       r_err_overflow <= 1'b1;
      else if (clr_err) r_err_overflow <= 1'b0;
    end
  end

  assign block_out    = r_mem[r_rd_ptr];
  assign block_valid  = r_valid;
  assign err_short    = r_err_short;
  assign err_overflow = r_err_overflow;
  assign block_count  = r_block_count;

endmodule
